// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill arbiter, the caches and the memory model.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package cache_pkg;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int MEM_LATENCY       = 4;

    localparam int WORD_IDX_W = $clog2(WORDS_PER_BLOCK);
    // One extra bit so a counter can hold WORDS_PER_BLOCK itself ("all done").
    localparam int CNT_W      = WORD_IDX_W + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        FILL  = 2'b10
    } arb_state_t;

    // Byte address of the first word of the block containing addr.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & BLOCK_MASK;
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Bundle between the I/D caches, the main memory and the fill arbiter.
// Latency: n/a (wires only).
// Backpressure: level requests held until the matching done pulse; memory has fixed latency.
// slave  : arbiter view (requests and memory responses in, memory commands and fill data out)
// master : environment view (caches + memory model), directions mirrored
interface cache_fill_arbiter_if;
    import cache_pkg::*;

    // cache requests
    logic                  i_miss;
    logic [ADDR_W-1:0]     i_miss_addr;
    logic                  d_miss;
    logic [ADDR_W-1:0]     d_miss_addr;
    logic                  d_wr_req;
    logic [ADDR_W-1:0]     d_wr_addr;
    logic [DATA_W-1:0]     d_wr_data;
    // memory port
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_data_valid;
    // fill return and completion
    logic [DATA_W-1:0]     fill_data;
    logic [WORD_IDX_W-1:0] fill_word;
    logic                  i_fill_we;
    logic                  d_fill_we;
    logic                  i_done;
    logic                  d_done;
    logic                  d_wr_done;
    logic                  busy;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_done, d_done, d_wr_done, busy
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_done, d_done, d_wr_done, busy
    );

endinterface

// File: rtl/word_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: 1 cycle from clr/en to cnt.
// Backpressure: none; holds at SAT while en stays high.
// Ports: clk, rst_n (async active-low), clr, en, cnt[W-1:0]
module word_counter #(
    parameter int W   = 4,
    parameter int SAT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT_V = W'(SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one fixed-latency main memory between I-cache fills, D-cache fills and D-side stores.
// Latency: store = 1 busy cycle; block fill = WORDS_PER_BLOCK + MEM_LATENCY busy cycles.
// Backpressure: requests are levels held until done; arbitration only in IDLE, no preemption.
// Ports: clk, rst_n (async active-low), bus (cache_fill_arbiter_if.slave)
module cache_fill_arbiter
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cache_fill_arbiter_if.slave  bus
);

    arb_state_t        state;
    logic              own_d;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rx_cnt;

    logic              cnt_clr;
    logic              issue_en;
    logic              issuing;
    logic              rx_open;
    logic              rx_take;
    logic              last_word;
    logic [ADDR_W-1:0] issue_off;

    // Counters are held at zero while idle, so every grant starts from a clean block.
    assign cnt_clr   = (state == IDLE);
    assign issue_en  = (state == FILL);
    assign issuing   = (state == FILL) && (issue_cnt < CNT_FULL);
    assign rx_open   = (state == FILL) && (rx_cnt < CNT_FULL);
    assign rx_take   = rx_open && bus.mem_data_valid;
    assign last_word = rx_take && (rx_cnt == CNT_LAST);
    // Word offset never exceeds the block, so OR-ing into the base cannot carry.
    assign issue_off = {{(ADDR_W-WORD_IDX_W-1){1'b0}}, issue_cnt[WORD_IDX_W-1:0], 1'b0};

    word_counter #(.W(CNT_W), .SAT(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (issue_en),
        .cnt   (issue_cnt)
    );

    word_counter #(.W(CNT_W), .SAT(WORDS_PER_BLOCK)) u_rx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (rx_take),
        .cnt   (rx_cnt)
    );

    // Store beats D fill beats I fill: the D side belongs to the older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            own_d   <= 1'b0;
            base    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.d_wr_req) begin
                        state   <= WRITE;
                        wr_addr <= bus.d_wr_addr & WORD_MASK;
                        wr_data <= bus.d_wr_data;
                    end else if (bus.d_miss) begin
                        state <= FILL;
                        own_d <= 1'b1;
                        base  <= block_base(bus.d_miss_addr);
                    end else if (bus.i_miss) begin
                        state <= FILL;
                        own_d <= 1'b0;
                        base  <= block_base(bus.i_miss_addr);
                    end
                end
                WRITE: state <= IDLE;
                FILL: begin
                    if (last_word) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic                  mem_en_c;
    logic                  mem_wr_c;
    logic [ADDR_W-1:0]     mem_addr_c;
    logic [DATA_W-1:0]     mem_wdata_c;
    logic [DATA_W-1:0]     fill_data_c;
    logic [WORD_IDX_W-1:0] fill_word_c;
    logic                  i_fill_we_c;
    logic                  d_fill_we_c;
    logic                  i_done_c;
    logic                  d_done_c;
    logic                  d_wr_done_c;

    // Everything reads zero in IDLE; only fill data, write enables and fill done
    // look at mem_data_valid, the rest is decoded from state and counters.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        fill_data_c = '0;
        fill_word_c = '0;
        i_fill_we_c = 1'b0;
        d_fill_we_c = 1'b0;
        i_done_c    = 1'b0;
        d_done_c    = 1'b0;
        d_wr_done_c = 1'b0;
        case (state)
            WRITE: begin
                mem_en_c    = 1'b1;
                mem_wr_c    = 1'b1;
                mem_addr_c  = wr_addr;
                mem_wdata_c = wr_data;
                d_wr_done_c = 1'b1;
            end
            FILL: begin
                if (issuing) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = base | issue_off;
                end
                if (rx_open) begin
                    fill_word_c = rx_cnt[WORD_IDX_W-1:0];
                end
                if (rx_take) begin
                    fill_data_c = bus.mem_rdata;
                    i_fill_we_c = !own_d;
                    d_fill_we_c = own_d;
                end
                if (last_word) begin
                    i_done_c = !own_d;
                    d_done_c = own_d;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_wr    = mem_wr_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.fill_data = fill_data_c;
    assign bus.fill_word = fill_word_c;
    assign bus.i_fill_we = i_fill_we_c;
    assign bus.d_fill_we = d_fill_we_c;
    assign bus.i_done    = i_done_c;
    assign bus.d_done    = d_done_c;
    assign bus.d_wr_done = d_wr_done_c;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter with a fixed-latency memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_fill_arbiter;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_fill_arbiter_if bus();

    cache_fill_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- memory model: reads return MEM_LATENCY cycles later ----------------
    bit [MEM_LATENCY-1:0] pipe_vld;
    bit [15:0]            pipe_dat [MEM_LATENCY];
    bit                   extra_vld;
    bit [15:0]            extra_dat;
    logic [15:0]          wmem   [32768];
    bit                   wvalid [32768];

    // reference image of memory, updated from the bench's own intent
    logic [15:0]          ref_wmem   [32768];
    bit                   ref_wvalid [32768];

    function automatic logic [15:0] init_word(input logic [14:0] idx);
        logic [31:0] t;
        t = {17'd0, idx} * 32'd40503 + 32'd12345;
        return t[15:0] ^ t[31:16];
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] byte_addr);
        logic [14:0] idx;
        idx = byte_addr[15:1];
        return ref_wvalid[idx] ? ref_wmem[idx] : init_word(idx);
    endfunction

    assign bus.mem_data_valid = pipe_vld[MEM_LATENCY-1] | extra_vld;
    assign bus.mem_rdata      = pipe_vld[MEM_LATENCY-1] ? pipe_dat[MEM_LATENCY-1] : extra_dat;

    always @(posedge clk) begin
        for (int s = MEM_LATENCY - 1; s > 0; s--) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_dat[s] <= pipe_dat[s-1];
        end
        pipe_vld[0] <= (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0);
        pipe_dat[0] <= wvalid[bus.mem_addr[15:1]] ? wmem[bus.mem_addr[15:1]]
                                                  : init_word(bus.mem_addr[15:1]);
        if ((bus.mem_en === 1'b1) && (bus.mem_wr === 1'b1)) begin
            wmem[bus.mem_addr[15:1]]   <= bus.mem_wdata;
            wvalid[bus.mem_addr[15:1]] <= 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.busy, bus.mem_en, bus.mem_wr, bus.i_fill_we, bus.d_fill_we,
                    bus.i_done, bus.d_done, bus.d_wr_done, bus.fill_word,
                    bus.mem_addr, bus.mem_wdata, bus.fill_data});
    endfunction

    // Request already raised while idle; checks the 12 busy cycles and the idle cycle after.
    task automatic expect_fill(input bit is_d, input logic [15:0] addr, input bit hold, input bit extra);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int j = 1; j <= WORDS_PER_BLOCK + MEM_LATENCY; j++) begin
            @(negedge clk);
            chk("fill_busy", bus.busy, 1);
            chk("fill_mem_en", bus.mem_en, 64'(j <= WORDS_PER_BLOCK));
            chk("fill_mem_wr", bus.mem_wr, 0);
            if (j <= WORDS_PER_BLOCK)
                chk("fill_rd_addr", bus.mem_addr, base + 16'(2 * (j - 1)));
            chk("fill_owner_we", is_d ? bus.d_fill_we : bus.i_fill_we, 64'(j > MEM_LATENCY));
            chk("fill_other_we", is_d ? bus.i_fill_we : bus.d_fill_we, 0);
            if (j > MEM_LATENCY) begin
                chk("fill_word", bus.fill_word, j - MEM_LATENCY - 1);
                chk("fill_data", bus.fill_data, ref_word(base + 16'(2 * (j - MEM_LATENCY - 1))));
            end
            chk("fill_owner_done", is_d ? bus.d_done : bus.i_done,
                64'(j == WORDS_PER_BLOCK + MEM_LATENCY));
            chk("fill_other_done", {(is_d ? bus.i_done : bus.d_done), bus.d_wr_done}, 0);
        end
        if (!hold) begin
            if (is_d) bus.d_miss = 1'b0;
            else      bus.i_miss = 1'b0;
        end
        if (extra) begin
            @(posedge clk);
            #1;
            extra_vld = 1'b1;
            extra_dat = 16'($urandom);
        end
        @(negedge clk);
        chk("fill_then_idle", {bus.busy, bus.mem_en, bus.i_fill_we, bus.d_fill_we,
                               bus.i_done, bus.d_done, bus.fill_data}, 0);
        extra_vld = 1'b0;
    endtask

    // Store already raised while idle; checks the WRITE cycle and the idle cycle after.
    task automatic expect_write(input logic [15:0] addr, input logic [15:0] data, input bit extra);
        if (extra) begin
            @(posedge clk);
            #1;
            extra_vld = 1'b1;
            extra_dat = 16'($urandom);
        end
        @(negedge clk);
        chk("wr_busy", bus.busy, 1);
        chk("wr_en_wr", {bus.mem_en, bus.mem_wr}, 2'b11);
        chk("wr_addr", bus.mem_addr, addr & 16'hFFFE);
        chk("wr_data", bus.mem_wdata, data);
        chk("wr_done", bus.d_wr_done, 1);
        chk("wr_no_fill", {bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done, bus.fill_data}, 0);
        ref_wmem[addr[15:1]]   = data;
        ref_wvalid[addr[15:1]] = 1'b1;
        bus.d_wr_req = 1'b0;
        extra_vld = 1'b0;
        @(negedge clk);
        chk("wr_then_idle", {bus.busy, bus.mem_en, bus.d_wr_done}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] a_i, a_d, a_w, w_dat;
        int r;

        rst_n           = 1'b0;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = '0;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = '0;
        bus.d_wr_req    = 1'b0;
        bus.d_wr_addr   = '0;
        bus.d_wr_data   = '0;
        extra_vld       = 1'b0;
        extra_dat       = '0;

        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", all_outs(), 0);

        // I fill of block 0x0230, extra valid after the 8th word
        bus.i_miss_addr = 16'h0236;
        bus.i_miss      = 1'b1;
        expect_fill(1'b0, 16'h0236, 1'b0, 1'b1);

        // store to odd address, with a stray valid during WRITE
        bus.d_wr_addr = 16'h1235;
        bus.d_wr_data = 16'hBEEF;
        bus.d_wr_req  = 1'b1;
        expect_write(16'h1235, 16'hBEEF, 1'b1);

        // D fill of the stored block returns the new word
        bus.d_miss_addr = 16'h123C;
        bus.d_miss      = 1'b1;
        expect_fill(1'b1, 16'h123C, 1'b0, 1'b0);

        // all three requests at once: store, then D fill, then I fill
        a_w = 16'h3000 | 16'($urandom_range(0, 63));
        a_d = 16'h3000 | 16'($urandom_range(0, 63));
        a_i = 16'h4000 | 16'($urandom_range(0, 255));
        w_dat = 16'($urandom);
        bus.d_wr_addr   = a_w;
        bus.d_wr_data   = w_dat;
        bus.d_miss_addr = a_d;
        bus.i_miss_addr = a_i;
        bus.d_wr_req    = 1'b1;
        bus.d_miss      = 1'b1;
        bus.i_miss      = 1'b1;
        expect_write(a_w, w_dat, 1'b0);
        expect_fill(1'b1, a_d, 1'b0, 1'b0);
        expect_fill(1'b0, a_i, 1'b0, 1'b0);

        // i_miss held past i_done is re-granted from the idle cycle
        a_i = 16'h5000 | 16'($urandom_range(0, 255));
        bus.i_miss_addr = a_i;
        bus.i_miss      = 1'b1;
        expect_fill(1'b0, a_i, 1'b1, 1'b0);
        expect_fill(1'b0, a_i, 1'b0, 1'b0);

        // reset in fill cycle 6; in-flight responses must be ignored
        a_i = 16'h2000 | 16'($urandom_range(0, 255));
        bus.i_miss_addr = a_i;
        bus.i_miss      = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk("rst_fill_rd_addr", bus.mem_addr, (a_i & 16'hFFF0) + 16'(2 * (j - 1)));
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_fill_outs", all_outs(), 0);
        bus.i_miss = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("late_valid_ignored", {bus.busy, bus.i_fill_we, bus.d_fill_we,
                                       bus.i_done, bus.d_done}, 0);
        end
        a_d = 16'h6000 | 16'($urandom_range(0, 255));
        bus.d_miss_addr = a_d;
        bus.d_miss      = 1'b1;
        expect_fill(1'b1, a_d, 1'b0, 1'b0);

        // random mixes of simultaneous requests over a small address window
        for (int k = 0; k < 12; k++) begin
            r     = $urandom_range(1, 7);
            a_w   = 16'h1000 | 16'($urandom_range(0, 63));
            a_d   = 16'h1000 | 16'($urandom_range(0, 63));
            a_i   = 16'h1000 | 16'($urandom_range(0, 63));
            w_dat = 16'($urandom);
            bus.d_wr_addr   = a_w;
            bus.d_wr_data   = w_dat;
            bus.d_miss_addr = a_d;
            bus.i_miss_addr = a_i;
            bus.d_wr_req    = r[0];
            bus.d_miss      = r[1];
            bus.i_miss      = r[2];
            if (r[0]) expect_write(a_w, w_dat, 1'($urandom_range(0, 1)));
            if (r[1]) expect_fill(1'b1, a_d, 1'b0, 1'($urandom_range(0, 1)));
            if (r[2]) expect_fill(1'b0, a_i, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Arbitrates the single multi-cycle main memory between the I-cache miss port and the D-cache, which has a miss port and a write-through store port. It sequences 8-word block fills and single-word stores. It sits between both caches and the memory model, replacing the separate IMEM/DMEM instances of the pipelined `cpu`. The pipeline stays stalled while the requesting cache's miss or store signal is high.

## Interface
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (16-byte block)
- MEM_LATENCY, 4, cycles from an issued read to the matching `mem_data_valid`
- ADDR_W, 16, byte-address width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_miss  in  1  I-cache fill request (level); held until `i_done`
- i_miss_addr  in  16  I-side miss byte address
- d_miss  in  1  D-cache fill request (level); held until `d_done`
- d_miss_addr  in  16  D-side miss byte address
- d_wr_req  in  1  write-through store request (level); held until `d_wr_done`
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  `mem_rdata` valid this cycle
- fill_data  out  16  word being filled; equals `mem_rdata`
- fill_word  out  3  word index within the block for `fill_data`
- i_fill_we  out  1  I-cache data-array write enable
- d_fill_we  out  1  D-cache data-array write enable
- i_done, d_done, d_wr_done  out  1  one-cycle completion pulses
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL.
- Owner register `own_d` records which cache owns the current FILL.
- Fixed priority, sampled in IDLE only: `d_wr_req` > `d_miss` > `i_miss`. The D side is the older instruction.
- A grant is never preempted.
- IDLE -> WRITE on `d_wr_req`. The store address is sampled in that cycle.
- WRITE lasts exactly 1 cycle:
  - `mem_en`=`mem_wr`=1, `mem_addr`=`d_wr_addr`&16'hFFFE, `mem_wdata`=`d_wr_data`, `d_wr_done`=1.
  - Then -> IDLE.
- IDLE -> FILL on a miss. The block base is latched as the granted address & 16'hFFF0. `issue_cnt` and `rx_cnt` are cleared.
- FILL issue phase, while `issue_cnt` < WORDS_PER_BLOCK:
  - `mem_en`=1, `mem_wr`=0, `mem_addr`=base | {`issue_cnt`,1'b0}.
  - `issue_cnt` increments every cycle.
- FILL receive phase: on each `mem_data_valid` with `rx_cnt` < WORDS_PER_BLOCK:
  - `fill_word`=`rx_cnt`, `fill_data`=`mem_rdata`.
  - The owner's `fill_we` is set to 1 and `rx_cnt` increments.
- On the cycle the last word arrives (`rx_cnt`==WORDS_PER_BLOCK-1 with `mem_data_valid`):
  - The owner's done pulse is asserted together with its `fill_we`.
  - Next state is IDLE.
- Requesters must drop their request in the cycle after their done pulse. IDLE re-arbitrates on that cycle.
- Arithmetic: counters are log2(WORDS_PER_BLOCK)+1 bits wide. The word offset is {count,1'b0}, so there is no carry into base bits [15:4].

## Timing
- Reset (async, any state): state=IDLE, counters=0, `own_d`=0. All outputs are 0 (`mem_addr`, `mem_wdata`, `fill_data` read 0 in IDLE).
- All outputs are Moore-decoded from state/counters, except `fill_data`, `fill_we`, and the done pulses in FILL, which also depend on `mem_data_valid`.
- Store: request seen at edge k -> memory write and `d_wr_done` in cycle k+1 -> IDLE at k+2.
- Fill granted at edge t:
  - Reads are issued in cycles t+1..t+8.
  - Data arrives in cycles t+1+MEM_LATENCY..t+8+MEM_LATENCY (t+5..t+12 with defaults).
  - Done pulses in cycle t+12; IDLE at t+13. Total 12 busy cycles.
- Boundary conditions:
  - `mem_data_valid` in IDLE, in WRITE, or after the 8th word is ignored.
  - Request lines changing mid-operation are ignored.
  - A reset mid-fill discards the partial block. No `fill_we` or done pulse follows. Memory responses already in flight are ignored because the block is in IDLE.

## Structure
- Shared package `cache_pkg`: state encoding (IDLE=2'b00, WRITE=2'b01, FILL=2'b10), WORDS_PER_BLOCK, BLOCK_OFFSET_BITS=4, MEM_LATENCY. The caches and the memory model use the same package.
- One sub-module, `word_counter`: a saturating up-counter with clear and enable, async active-low reset. It is instantiated twice, for `issue_cnt` and `rx_cnt`.

## Test plan
- `i_miss`=1 with `i_miss_addr`=16'h0236 -> reads at 0x0230..0x023E in consecutive cycles; 8 `i_fill_we` pulses with `fill_word` 0..7; `i_done` 12 cycles after the grant; `d_fill_we` stays 0.
- `d_wr_req`, `d_miss` and `i_miss` all rising in the same cycle -> order WRITE, then D fill, then I fill; exactly one done pulse each.
- Store to 16'h1235 with data 16'hBEEF -> one cycle with `mem_wr`=1, `mem_addr`=16'h1234, `mem_wdata`=16'hBEEF; `d_wr_done` in the same cycle.
- Memory model with MEM_LATENCY=4 and an extra `mem_data_valid` after the 8th word -> no 9th `fill_we`; `rx_cnt` stays saturated.
- `rst_n` asserted low at fill cycle 6 -> all outputs 0 immediately. After release, late `mem_data_valid` pulses cause no `fill_we`; a new `d_miss` completes normally.
- `i_miss` held through the cycle after `i_done` -> a second fill is granted. This checks the IDLE re-arbitration point.
